// File: rtl/core_pkg.sv
// Shared types for the ID-stage hazard controller: tracking entry, FSM states
// and the "stage writes register" predicate.
package core_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
    } stage_track_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HOLD  = 2'd2
    } ctrl_state_t;

    // x0 is hardwired, so a write to it never produces a dependency
    function automatic logic stage_writes(input stage_track_t s, input logic [REG_W-1:0] r);
        return s.valid & s.reg_write & (s.rd == r) & (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_track_pipe.sv
// Three-entry shadow of the EX/MEM/WB destination info; frozen as a whole
// while the pipeline is held, otherwise shifts one slot per cycle.
module hazard_track_pipe
    import core_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         freeze,
    input  stage_track_t id_entry,
    output stage_track_t ex,
    output stage_track_t mem,
    output stage_track_t wb
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex  <= '0;
            mem <= '0;
            wb  <= '0;
        end else if (!freeze) begin
            wb  <= mem;
            mem <= ex;
            ex  <= id_entry;
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard and branch controller: load-use / branch-operand / WB RAW
// detection, ID branch resolution, freeze handling and stall counting.
//
// state | meaning
// RUN   | pipeline advancing (normal issue or taken-branch redirect)
// STALL | RAW hazard held ID, bubble sent to EX
// HOLD  | external freeze, everything held
module id_hazard_ctrl
    import core_pkg::*;
#(
    parameter int STALL_CNT_W = 16,
    parameter int REG_ADDR_W  = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic [REG_ADDR_W-1:0]  id_rd,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   id_branch,
    input  logic                   id_branch_ne,
    input  logic                   id_equal,
    input  logic                   ext_hold,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idex_bubble,
    output logic                   pc_sel_branch,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic [1:0]             state_o
);

    stage_track_t ex, mem, wb, id_entry;
    ctrl_state_t  state;
    logic         use1, use2, ex_hit, mem_hit, wb_hit;
    logic         hold, raw, taken;

    assign use1 = id_use_rs1 & (id_rs1 != REG_ZERO);
    assign use2 = id_use_rs2 & (id_rs2 != REG_ZERO);

    assign ex_hit  = (use1 & stage_writes(ex,  id_rs1)) | (use2 & stage_writes(ex,  id_rs2));
    assign mem_hit = (use1 & stage_writes(mem, id_rs1)) | (use2 & stage_writes(mem, id_rs2));
    assign wb_hit  = (use1 & stage_writes(wb,  id_rs1)) | (use2 & stage_writes(wb,  id_rs2));

    // Gating with rst_n keeps the outputs at their idle values while reset is held
    assign hold  = rst_n & ext_hold;
    assign raw   = rst_n & id_valid &
                   ((ex_hit & ex.mem_read) | (id_branch & (ex_hit | mem_hit)) | wb_hit);
    assign taken = rst_n & id_valid & id_branch & (id_equal ^ id_branch_ne) & ~raw & ~hold;

    assign pc_write      = ~(hold | raw);
    assign ifid_write    = ~(hold | raw);
    assign idex_bubble   = raw & ~hold;
    assign ifid_flush    = taken;
    assign pc_sel_branch = taken;

    assign id_entry.valid     = id_valid & ~idex_bubble;
    assign id_entry.rd        = id_rd;
    assign id_entry.reg_write = id_reg_write & ~taken;
    assign id_entry.mem_read  = id_mem_read;

    hazard_track_pipe u_track (
        .clk      (clk),
        .rst_n    (rst_n),
        .freeze   (hold),
        .id_entry (id_entry),
        .ex       (ex),
        .mem      (mem),
        .wb       (wb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            stall_cnt <= '0;
        end else if (hold) begin
            state <= HOLD;
        end else if (raw) begin
            state <= STALL;
            if (stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end else begin
            state <= RUN;
        end
    end

    assign state_o = state;

endmodule
